if_id_stage: RTL
================

// Module: if_id_stage
// PURPOSE
//  Parametrised IF/ID pipeline stage with a valid/ready handshake on both sides.
//  Captures the fetched instruction and PC, and decodes rd/rs1/rs2 plus a
//  sign-extended immediate in one cycle.
//  A 2-entry skid buffer keeps in_ready registered (no combinational ready path),
//  so a stalled decode never drops a fetch. Flush squashes wrong-path instructions.
//  Sits between the fetch unit and the register-read/decode stage.
// PARAMETERS
//  WordSize  32  width of PC and imm; must be >= 32; imm is sign/zero-extended to WordSize
// PORTS
//  clk        in   1         clock, rising edge
//  rstn       in   1         asynchronous, active-low reset
//  flush      in   1         squash all held entries (branch/exception redirect)
//  in_valid   in   1         fetch presents ins/pc_in/immode
//  in_ready   out  1         stage can accept this cycle (registered)
//  ins        in   32        raw instruction word
//  pc_in      in   WordSize  PC of ins
//  immode     in   3         immediate format select (see BEHAVIOUR)
//  out_valid  out  1         decoded entry available
//  out_ready  in   1         downstream accepts this cycle
//  rdn        out  5         ins[11:7]
//  rs1n       out  5         ins[19:15]
//  rs2n       out  5         ins[24:20]
//  imm        out  WordSize  decoded immediate
//  pc         out  WordSize  PC of the presented entry
// BEHAVIOUR
//  Reset: all entries invalid. out_valid=0, in_ready=1, rdn/rs1n/rs2n=0, imm=0, pc=0.
//  Storage: main register (drives outputs) plus skid register. Decode happens on
//   capture, so an entry's fields are final when stored.
//  Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  in_ready = !skid_valid, registered.
//  Latency: 1 cycle from in_fire to out_valid when main is empty or draining.
//  Per cycle, priority in this order:
//   1 flush: main_valid=0, skid_valid=0, any in_fire that cycle is discarded.
//     Next cycle in_ready=1 and out_valid=0. Data fields keep their old values.
//   2 main empty or out_fire, with skid valid: skid->main; in_fire (if any)->skid.
//   3 main empty or out_fire, with skid empty: in_fire->main, else main_valid=0.
//   4 main held (out_valid & !out_ready) with in_fire: entry->skid, in_ready=0 next cycle.
//  Order is preserved; no entry is duplicated or lost except by flush.
//  Outputs are stable while out_valid & !out_ready.
//  immode: 0 none (imm=0)
//   1 I  sext(ins[31:20])
//   2 S  sext({ins[31:25],ins[11:7]})
//   3 B  sext({ins[31],ins[7],ins[30:25],ins[11:8],1'b0})
//   4 U  sext({ins[31:12],12'b0})
//   5 J  sext({ins[31],ins[19:12],ins[20],ins[30:21],1'b0})
//   6 SH zext(ins[24:20])
//   7 Z  zext(ins[19:15]) (CSR zimm)
//  sext/zext extend to WordSize. At WordSize=32, U-format needs no extension.
//  Reset asserted mid-operation clears both entries asynchronously. No partial state survives.
// CONFIGURATION
//  IFID_PERF_EN defined:
//   - adds output stall_cnt [31:0], reset 0.
//   - increments by 1 each cycle out_valid & !out_ready; wraps 0xFFFFFFFF->0.
//   - cleared by reset only; not by flush.
//  IFID_PERF_EN undefined: the port and counter do not exist; behaviour otherwise identical.
// TESTING
//  1 reset then ins=0xFFF00093, immode=1, pc_in=0x100, out_ready=1
//    -> next cycle: out_valid=1, rdn=1, rs1n=0, imm=0xFFFFFFFF, pc=0x100.
//  2 ins=0xFFDFF0EF, immode=5 -> imm=0xFFFFFFFC, rdn=1.
//    Same ins with immode=4 -> imm=0xFFDFF000. immode=0 -> imm=0.
//  3 out_ready=0, send pc 0x10 then 0x14 back-to-back
//    -> in_ready=0 after the 2nd accept. Outputs hold pc=0x10.
//    Raise out_ready -> pc 0x10 then 0x14 on consecutive cycles. in_ready=1 again.
//  4 both entries full, flush=1 with in_valid=1 (pc 0x18)
//    -> next cycle out_valid=0, in_ready=1. pc 0x18 never appears at the output.
//  5 assert rstn=0 asynchronously mid-stall -> out_valid=0, in_ready=1 immediately.
//    Fields are 0; stall_cnt=0 when IFID_PERF_EN is defined.
//  6 IFID_PERF_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5.
//    Force counter to 0xFFFFFFFF, stall 1 cycle -> stall_cnt=0.

Source files
------------

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with valid/ready handshakes on both
// sides. A main register drives the outputs. A skid register absorbs one
// extra fetch while decode is stalled. This keeps in_ready a pure flop output,
// with no combinational path from out_ready.
// rd/rs1/rs2 and the immediate are decoded when an entry is captured, so
// stored entries already hold their final field values.
// WordSize (PC and immediate width) must be at least 32.
// Optional feature: define IFID_PERF_EN to add the stall_cnt output, a 32-bit
// wrapping count of cycles with out_valid & !out_ready.

module if_id_stage #(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         ins,
  input  logic [WordSize-1:0] pc_in,
  input  logic [2:0]          immode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          rdn,
  output logic [4:0]          rs1n,
  output logic [4:0]          rs2n,
  output logic [WordSize-1:0] imm,
  output logic [WordSize-1:0] pc
`ifdef IFID_PERF_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_SH   = 3'd6,
    IMM_Z    = 3'd7
  } imm_mode_e;

  typedef struct packed {
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [WordSize-1:0] imm;
    logic [WordSize-1:0] pc;
  } entry_t;

  // Immediate decode. A size cast of a signed temporary sign-extends it.
  // A size cast of an unsigned slice zero-extends it.
  function automatic logic [WordSize-1:0] decode_imm(input logic [31:0] i,
                                                     input logic [2:0]  mode);
    logic signed [11:0]  imm12;
    logic signed [12:0]  imm13;
    logic signed [20:0]  imm21;
    logic signed [31:0]  imm32;
    logic [WordSize-1:0] res;
    imm12 = '0;
    imm13 = '0;
    imm21 = '0;
    imm32 = '0;
    res   = '0;
    case (imm_mode_e'(mode))
      IMM_I: begin
        imm12 = i[31:20];
        res   = WordSize'(imm12);
      end
      IMM_S: begin
        imm12 = {i[31:25], i[11:7]};
        res   = WordSize'(imm12);
      end
      IMM_B: begin
        imm13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        res   = WordSize'(imm13);
      end
      IMM_U: begin
        imm32 = {i[31:12], 12'b0};
        res   = WordSize'(imm32);
      end
      IMM_J: begin
        imm21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        res   = WordSize'(imm21);
      end
      IMM_SH:  res = WordSize'(i[24:20]);
      IMM_Z:   res = WordSize'(i[19:15]);
      default: res = '0;
    endcase
    return res;
  endfunction

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   in_fire;
  logic   out_fire;
  logic   main_free;
  logic   unused_opcode;

  // The opcode bits ins[6:0] are decoded by the next stage, not here.
  assign unused_opcode = ^ins[6:0];

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = main_valid_q & out_ready;
  assign main_free = ~main_valid_q | out_fire;

  // Decode the incoming fetch, so it is ready to store in either register.
  always_comb begin
    in_entry.rd  = ins[11:7];
    in_entry.rs1 = ins[19:15];
    in_entry.rs2 = ins[24:20];
    in_entry.imm = decode_imm(ins, immode);
    in_entry.pc  = pc_in;
  end

  // Next state of the main and skid registers. Flush has top priority, then
  // a refill of main (from skid first, to keep order), then parking in skid.
  always_comb begin
    // NOTE: every signal driven here gets a default first. Any path that
    // left one unassigned would infer a latch.
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // A flush clears only the valid bits. The data fields keep their old values.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = in_fire;
        if (in_fire) begin
          skid_d = in_entry;
        end
      end else if (in_fire) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the entry storage is reset as well. The outputs must read zero
      // after reset, and no stale field may survive a mid-operation reset.
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values.
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign rdn       = main_q.rd;
  assign rs1n      = main_q.rs1;
  assign rs2n      = main_q.rs2;
  assign imm       = main_q.imm;
  assign pc        = main_q.pc;

`ifdef IFID_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where an entry is presented but not taken. The count wraps.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register. Only reset clears it; flush does not.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
